// File: rtl/net_pkg.sv
// Shared types and constants for the Petri-net result monitor.
package net_pkg;

  localparam int unsigned LED_W      = 6;
  localparam int unsigned RESULT_MAX = 63;
  localparam int unsigned FIRE_ID_W  = 5;
  localparam int unsigned DATA_W     = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  // Clamp the output-place marking to what the LED bank can show.
  function automatic logic [LED_W-1:0] clamp_result(input logic [DATA_W-1:0] tokens);
    if (tokens > DATA_W'(RESULT_MAX)) begin
      return LED_W'(RESULT_MAX);
    end
    return tokens[LED_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[DATA_W] ? '1 : sum[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/net_blink_div.sv
// Free-running divider producing a one-cycle tick every DIV enabled cycles.
module net_blink_div #(
  parameter int unsigned DIV = 13500000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic en,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_c = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        tick_c = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/net_result_monitor.sv
// Watches the net firing stream, declares quiescence or timeout, and shows
// the output-place marking on active-low LEDs.
module net_result_monitor
  import net_pkg::*;
#(
  parameter int unsigned QUIET_CYCLES = 4,
  parameter int unsigned MAX_CYCLES   = 1000000,
  parameter int unsigned BLINK_DIV    = 13500000
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 start,
  input  logic [FIRE_ID_W-1:0] fire_id,
  input  logic [DATA_W-1:0]    fire_count,
  input  logic [DATA_W-1:0]    out_tokens,
  output logic [LED_W-1:0]     led,
  output logic                 done,
  output logic                 timeout,
  output logic [DATA_W-1:0]    cycle_cnt,
  output logic [DATA_W-1:0]    fire_total
);

  localparam int unsigned QW = $clog2(QUIET_CYCLES + 1);
  localparam logic [QW-1:0]     QUIET_LAST = QW'(QUIET_CYCLES - 1);
  localparam logic [DATA_W-1:0] CYCLE_LAST = DATA_W'(MAX_CYCLES - 1);

  state_e             state_q, state_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;
  logic [DATA_W-1:0]  cycle_cnt_q, cycle_cnt_d;
  logic [DATA_W-1:0]  fire_total_q, fire_total_d;
  logic [QW-1:0]      quiet_cnt_q, quiet_cnt_d;
  logic [LED_W-1:0]   result_q, result_d;
  logic               blink_tick_c;

  net_blink_div #(
    .DIV (BLINK_DIV)
  ) u_blink (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .en        (state_q == ST_TIMEOUT),
    .clr       (start),
    .tick_c    (blink_tick_c)
  );

  always_comb begin
    state_d      = state_q;
    cycle_cnt_d  = cycle_cnt_q;
    fire_total_d = fire_total_q;
    quiet_cnt_d  = quiet_cnt_q;
    result_d     = result_q;
    led_d        = led_q;

    if (state_q == ST_RUN) begin
      if (cycle_cnt_q != '1) begin
        cycle_cnt_d = cycle_cnt_q + DATA_W'(1);
      end
      if (fire_id != '0) begin
        fire_total_d = sat_add(fire_total_q, fire_count);
        quiet_cnt_d  = '0;
      end else begin
        quiet_cnt_d  = quiet_cnt_q + QW'(1);
      end
      // Quiescence has priority over the cycle budget.
      if ((fire_id == '0) && (quiet_cnt_q == QUIET_LAST)) begin
        state_d  = ST_DONE;
        result_d = clamp_result(out_tokens);
      end else if (cycle_cnt_q == CYCLE_LAST) begin
        state_d = ST_TIMEOUT;
      end
    end

    // A start pulse always wins: fresh run, no quiescence/timeout decision.
    if (start) begin
      state_d      = ST_RUN;
      cycle_cnt_d  = '0;
      fire_total_d = '0;
      quiet_cnt_d  = '0;
      result_d     = result_q;
    end

    case (state_d)
      ST_IDLE:    led_d = '1;
      ST_RUN:     led_d = ~out_tokens[LED_W-1:0];
      ST_DONE:    led_d = ~result_d;
      ST_TIMEOUT: begin
        if (state_q != ST_TIMEOUT) begin
          led_d = '0;
        end else if (blink_tick_c) begin
          led_d = ~led_q;
        end
      end
      default:    led_d = '1;
    endcase

    done_d    = (state_d == ST_DONE);
    timeout_d = (state_d == ST_TIMEOUT);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= ST_IDLE;
      led_q        <= '1;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      cycle_cnt_q  <= '0;
      fire_total_q <= '0;
      quiet_cnt_q  <= '0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      led_q        <= led_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      cycle_cnt_q  <= cycle_cnt_d;
      fire_total_q <= fire_total_d;
      quiet_cnt_q  <= quiet_cnt_d;
      result_q     <= result_d;
    end
  end

  assign led        = led_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign cycle_cnt  = cycle_cnt_q;
  assign fire_total = fire_total_q;

endmodule

// File: tb/tb_net_result_monitor.sv
// Directed bench for net_result_monitor with a done/timeout event scoreboard.
module tb_net_result_monitor;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        start;
  logic [4:0]  fire_id;
  logic [31:0] fire_count;
  logic [31:0] out_tokens;
  logic [5:0]  led;
  logic        done;
  logic        timeout;
  logic [31:0] cycle_cnt;
  logic [31:0] fire_total;

  typedef struct packed {
    logic        done;
    logic        timeout;
    logic [5:0]  led;
    logic [31:0] total;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  logic prev_done = 1'b0;
  logic prev_to   = 1'b0;

  net_result_monitor #(
    .QUIET_CYCLES (4),
    .MAX_CYCLES   (20),
    .BLINK_DIV    (3)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .start      (start),
    .fire_id    (fire_id),
    .fire_count (fire_count),
    .out_tokens (out_tokens),
    .led        (led),
    .done       (done),
    .timeout    (timeout),
    .cycle_cnt  (cycle_cnt),
    .fire_total (fire_total)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic expect_done(input logic [5:0] l, input logic [31:0] total, input logic [31:0] cnt);
    sb_q.push_back('{done: 1'b1, timeout: 1'b0, led: l, total: total, cnt: cnt});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_led"}, 32'(led), 32'h3F);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_timeout"}, 32'(timeout), 0);
    chk({tag, "_cycle_cnt"}, cycle_cnt, 0);
    chk({tag, "_fire_total"}, fire_total, 0);
  endtask

  // Monitor: pop and compare on every rising edge of done or timeout.
  always @(negedge sys_clk) begin
    if (sys_rst_n && ((done && !prev_done) || (timeout && !prev_to))) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: done=%0b timeout=%0b cycle_cnt=%0d with no event expected",
                 done, timeout, cycle_cnt);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_done", 32'(done), 32'(e.done));
        chk("sb_timeout", 32'(timeout), 32'(e.timeout));
        chk("sb_led", 32'(led), 32'(e.led));
        chk("sb_fire_total", fire_total, e.total);
        chk("sb_cycle_cnt", cycle_cnt, e.cnt);
      end
    end
    prev_done = done;
    prev_to   = timeout;
  end

  initial begin
    sys_rst_n  = 1'b0;
    start      = 1'b0;
    fire_id    = '0;
    fire_count = '0;
    out_tokens = '0;
    step(2);
    chk_reset_vals("reset");
    sys_rst_n = 1'b1;
    step(2);
    chk("idle_led", 32'(led), 32'h3F);

    // Basic run: 5 firings of 2, then 4 quiet cycles with 5 tokens.
    expect_done(6'b111010, 32'd10, 32'd9);
    pulse_start();
    fire_id = 5'd3; fire_count = 32'd2; out_tokens = 32'd9;
    step(1);
    chk("run_led_live", 32'(led), 32'h36);
    chk("run_cycle_cnt", cycle_cnt, 1);
    step(4);
    chk("run_fire_total", fire_total, 10);
    fire_id = '0; out_tokens = 32'd5;
    step(3);
    chk("quiet3_no_done", 32'(done), 0);
    step(1);
    chk("quiet4_done", 32'(done), 1);
    fire_id = 5'd7; fire_count = 32'd100; out_tokens = 32'd40;
    step(3);
    chk("done_hold_led", 32'(led), 32'h3A);
    chk("done_hold_cnt", cycle_cnt, 9);
    chk("done_hold_total", fire_total, 10);

    // Quiet run broken by a single firing.
    expect_done(6'b111000, 32'd1, 32'd8);
    pulse_start();
    chk("restart_from_done", 32'(done), 0);
    fire_id = '0; out_tokens = 32'd7;
    step(3);
    chk("broken_quiet_no_done", 32'(done), 0);
    fire_id = 5'd2; fire_count = 32'd1;
    step(1);
    fire_id = '0;
    step(4);
    chk("broken_quiet_done", 32'(done), 1);

    // Result saturates at 63 -> all LEDs lit.
    expect_done(6'b000000, 32'd5, 32'd5);
    pulse_start();
    fire_id = 5'd1; fire_count = 32'd5;
    step(1);
    fire_id = '0; out_tokens = 32'd200;
    step(4);

    // fire_total saturation.
    expect_done(6'b111111, 32'hFFFF_FFFF, 32'd6);
    pulse_start();
    fire_id = 5'd4; fire_count = 32'hFFFF_FFF0; out_tokens = 32'd0;
    step(2);
    chk("sat_total", fire_total, 32'hFFFF_FFFF);
    fire_id = '0;
    step(4);

    // Restart in the middle of a run.
    expect_done(6'b111110, 32'd6, 32'd6);
    pulse_start();
    fire_id = 5'd5; fire_count = 32'd3;
    step(3);
    fire_id = '0;
    pulse_start();
    chk("midrun_restart_cnt", cycle_cnt, 0);
    chk("midrun_restart_total", fire_total, 0);
    fire_id = 5'd5;
    step(2);
    fire_id = '0; out_tokens = 32'd1;
    step(4);

    // Timeout after 20 busy cycles, then blink.
    sb_q.push_back('{done: 1'b0, timeout: 1'b1, led: 6'b000000, total: 32'd20, cnt: 32'd20});
    pulse_start();
    fire_id = 5'd1; fire_count = 32'd1; out_tokens = 32'd3;
    step(19);
    chk("pre_timeout", 32'(timeout), 0);
    step(1);
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("blink_%0d", k), 32'(led), ((k / 3) % 2 == 1) ? 32'h3F : 32'h0);
      chk($sformatf("blink_cnt_%0d", k), cycle_cnt, 20);
      step(1);
    end

    // Restart from timeout, then reset mid-run.
    pulse_start();
    chk("restart_from_timeout", 32'(timeout), 0);
    fire_id = 5'd6; fire_count = 32'd4;
    step(3);
    sys_rst_n = 1'b0;
    #1;
    chk_reset_vals("midrun_reset");
    step(1);
    sys_rst_n = 1'b1;
    fire_id = '0; out_tokens = 32'd2;
    step(2);
    chk("post_reset_idle_led", 32'(led), 32'h3F);
    chk("post_reset_idle_cnt", cycle_cnt, 0);
    expect_done(6'b111101, 32'd0, 32'd4);
    pulse_start();
    step(4);
    step(2);

    chk("sb_drain", 32'(sb_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/net_result_monitor.md
NET_RESULT_MONITOR -- requirements
Module: net_result_monitor

Interface
REQ-001 Parameter QUIET_CYCLES, default 4, is the number of consecutive no-fire cycles that declares the net dead.
REQ-002 Parameter MAX_CYCLES, default 1000000, is the RUN cycle budget before timeout.
REQ-003 Parameter BLINK_DIV, default 13500000, is the number of cycles per LED toggle in TIMEOUT (0.5 s at 27 MHz).
REQ-004 Port sys_clk, input, 1 bit, is the single clock; all logic SHALL be on its rising edge.
REQ-005 Port sys_rst_n, input, 1 bit, is the asynchronous active-low reset.
REQ-006 Port start, input, 1 bit, is a single-cycle pulse that begins or restarts observation.
REQ-007 Port fire_id, input, 5 bits, is the index of the transition fired this cycle by the upstream net stage, 1..16; 0 means no transition enabled.
REQ-008 Port fire_count, input, 32 bits, is the firing multiplicity of the fired transition; it is valid only when fire_id != 0.
REQ-009 Port out_tokens, input, 32 bits, is the current marking of the output place.
REQ-010 Port led, output, 6 bits, drives the active-low LEDs.
REQ-011 Port done, output, 1 bit, is high while the net is quiescent and the result is latched.
REQ-012 Port timeout, output, 1 bit, is high when MAX_CYCLES was exhausted.
REQ-013 Port cycle_cnt, output, 32 bits, is the number of RUN cycles elapsed.
REQ-014 Port fire_total, output, 32 bits, is the sum of fire_count over the run.

Function
REQ-015 The block SHALL implement the FSM states IDLE, RUN, DONE and TIMEOUT.
REQ-016 IDLE: led = 6'b111111, done = 0, timeout = 0; start -> RUN.
REQ-017 On entry to RUN from any state, cycle_cnt, fire_total, quiet_cnt and the blink counter SHALL clear to 0 in the start cycle.
REQ-018 RUN, each cycle: cycle_cnt +1, saturating at 32'hFFFFFFFF.
REQ-019 RUN with fire_id != 0: fire_total += fire_count, saturating at 32'hFFFFFFFF; quiet_cnt <= 0.
REQ-020 RUN with fire_id == 0: quiet_cnt +1; quiet_cnt is sized for QUIET_CYCLES.
REQ-021 RUN: led = ~out_tokens[5:0] live, combinational from the register of the previous cycle, with one cycle of latency.
REQ-022 When fire_id == 0 and quiet_cnt == QUIET_CYCLES-1: next state DONE, and result <= min(out_tokens, 63) is latched in that same cycle.
REQ-023 When cycle_cnt == MAX_CYCLES-1 in RUN and REQ-022 is not met: next state TIMEOUT.
REQ-024 If REQ-022 and REQ-023 hold in the same cycle, DONE SHALL win.
REQ-025 DONE: led = ~result, done = 1, and all counters SHALL freeze; start -> RUN; all other inputs are ignored.
REQ-026 TIMEOUT: timeout = 1 and counters frozen.
REQ-027 TIMEOUT: led toggles between 6'b000000 and 6'b111111 every BLINK_DIV cycles, starting at 6'b000000 on entry; start -> RUN.
REQ-028 start asserted during RUN SHALL restart per REQ-017 and remain in RUN; quiescence evaluation is suppressed in that cycle.
REQ-029 done and timeout SHALL be registered outputs and mutually exclusive.

Reset
REQ-030 On sys_rst_n low, the block SHALL asynchronously force: state IDLE, led 6'b111111, done 0, timeout 0, cycle_cnt 0, fire_total 0, result 0, quiet_cnt 0, blink counter 0.
REQ-031 Reset asserted mid-RUN SHALL discard the run, and the block SHALL await a new start after release.

Structure
REQ-032 Shared package net_pkg SHALL hold the state enum, LED_W = 6, RESULT_MAX = 63 and the FIRE_ID_W = 5 constant.
REQ-033 One sub-module, net_blink_div, SHALL implement the BLINK_DIV toggle counter with enable and synchronous clear.

Verification
REQ-034 Reset, then start, then fire_id = 3 with fire_count = 2 for 5 cycles, then fire_id = 0 for 4 cycles with out_tokens = 5: done = 1 on the cycle after the 4th quiet cycle, led = 6'b111010, fire_total = 10, cycle_cnt = 9.
REQ-035 With MAX_CYCLES = 20 and BLINK_DIV = 3, fire_id = 1 continuously: timeout = 1 after 20 RUN cycles, and led alternates 000000 / 111111 every 3 cycles.
REQ-036 out_tokens = 200 at quiescence: result saturates, led = 6'b000000 in DONE.
REQ-037 Quiet cycles 3, then fire_id = 2 for one cycle, then 4 quiet cycles: no done after the first 3 quiet cycles; done asserted after the second quiet run.
REQ-038 fire_count = 32'hFFFFFFF0 fired twice: fire_total = 32'hFFFFFFFF.
REQ-039 sys_rst_n pulsed low mid-RUN: all outputs return to their reset values immediately; a subsequent start runs cleanly from cycle_cnt = 0.
